// File: rtl/sqrt_iter_param.sv
// sqrt_iter_param: iterative integer square root engine.
//   Computes out_root = floor(sqrt(in_radicand)) and out_rem = in_radicand - out_root^2
//   with the restoring digit-by-digit method. Each CALC clock resolves UNROLL root bits.
//   Control (IDLE/CALC/DONE FSM) and datapath live in this one block.
// Parameters:
//   WIDTH   radicand width (even, >= 4)
//   UNROLL  root bits resolved per CALC cycle (must divide WIDTH/2)
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any operation)
//   in_init      start request, only honoured in IDLE
//   in_radicand  operand, captured in the cycle in_init is accepted
//   out_busy     high in CALC and DONE
//   out_done     one-cycle pulse, results valid in that cycle
//   out_root     floor(sqrt(radicand)), held until next completion or reset
//   out_rem      radicand - root^2 (at most 2*root), held like out_root
module sqrt_iter_param #(
  parameter int WIDTH  = 16,
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_init,
  input  logic [WIDTH-1:0]     in_radicand,
  output logic                 out_busy,
  output logic                 out_done,
  output logic [WIDTH/2-1:0]   out_root,
  output logic [WIDTH/2:0]     out_rem
);

  localparam int N    = WIDTH / 2;
  localparam int ITER = N / UNROLL;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] x_nxt;
  logic [N+1:0]     r;
  logic [N+1:0]     r_nxt;
  logic [N-1:0]     q;
  logic [N-1:0]     q_nxt;
  logic [CW-1:0]    count;

  // One restoring step: bring down the next radicand bit pair, try to subtract
  // the trial divisor {q,01}; keep the difference only if it is non-negative.
  // The partial remainder never exceeds 2*q, so shifting r[N-1:0] loses nothing.
  function automatic logic [2*N+1:0] sqrt_step(input logic [N+1:0] r_in,
                                               input logic [N-1:0] q_in,
                                               input logic [1:0]   pair);
    logic [N+1:0] r_sh;
    logic [N+1:0] t;
    r_sh = {r_in[N-1:0], pair};
    t    = {q_in, 2'b01};
    if (r_sh >= t) return {r_sh - t, q_in[N-2:0], 1'b1};
    else           return {r_sh, q_in[N-2:0], 1'b0};
  endfunction

  always_comb begin
    x_nxt = x;
    r_nxt = r;
    q_nxt = q;
    for (int i = 0; i < UNROLL; i++) begin
      {r_nxt, q_nxt} = sqrt_step(r_nxt, q_nxt, x_nxt[WIDTH-1 -: 2]);
      x_nxt = x_nxt << 2;
    end
  end

  always_comb begin
    state_nxt = state;
    out_busy  = 1'b0;
    out_done  = 1'b0;
    case (state)
      IDLE: begin
        if (in_init) state_nxt = CALC;
      end
      CALC: begin
        out_busy = 1'b1;
        if (count == '0) state_nxt = DONE;
      end
      DONE: begin
        out_busy  = 1'b1;
        out_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      r        <= '0;
      q        <= '0;
      count    <= '0;
      out_root <= '0;
      out_rem  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_init) begin
            x     <= in_radicand;
            r     <= '0;
            q     <= '0;
            count <= CW'(ITER - 1);
          end
        end
        CALC: begin
          x <= x_nxt;
          r <= r_nxt;
          q <= q_nxt;
          if (count == '0) begin
            // Results are loaded on entry to DONE so they are visible with out_done.
            out_root <= q_nxt;
            out_rem  <= r_nxt[N:0];
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_param.sv
// tb_sqrt_iter_param: scoreboard bench for sqrt_iter_param.
//   Four instances (W16/U1, W16/U2, W8/U4, W32/U2) share clock, reset, start and a
//   32-bit operand (each takes its low WIDTH bits). The stimulus task keeps a model
//   of each instance's busy window and pushes expected results into a scoreboard;
//   a negedge monitor pops them when out_done is due and checks every output.
module tb_sqrt_iter_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_init;
  logic [31:0] rad;

  always #5 clk = ~clk;

  logic        busy_w [4];
  logic        done_w [4];
  logic [31:0] root_o [4];
  logic [31:0] rem_o  [4];

  logic [7:0]  root_a, root_b;
  logic [8:0]  rem_a,  rem_b;
  logic [3:0]  root_c;
  logic [4:0]  rem_c;
  logic [15:0] root_d;
  logic [16:0] rem_d;

  sqrt_iter_param #(.WIDTH(16), .UNROLL(1)) u_a (
    .clk(clk), .rst(rst), .in_init(in_init), .in_radicand(rad[15:0]),
    .out_busy(busy_w[0]), .out_done(done_w[0]), .out_root(root_a), .out_rem(rem_a));
  sqrt_iter_param #(.WIDTH(16), .UNROLL(2)) u_b (
    .clk(clk), .rst(rst), .in_init(in_init), .in_radicand(rad[15:0]),
    .out_busy(busy_w[1]), .out_done(done_w[1]), .out_root(root_b), .out_rem(rem_b));
  sqrt_iter_param #(.WIDTH(8), .UNROLL(4)) u_c (
    .clk(clk), .rst(rst), .in_init(in_init), .in_radicand(rad[7:0]),
    .out_busy(busy_w[2]), .out_done(done_w[2]), .out_root(root_c), .out_rem(rem_c));
  sqrt_iter_param #(.WIDTH(32), .UNROLL(2)) u_d (
    .clk(clk), .rst(rst), .in_init(in_init), .in_radicand(rad),
    .out_busy(busy_w[3]), .out_done(done_w[3]), .out_root(root_d), .out_rem(rem_d));

  assign root_o[0] = 32'(root_a);
  assign rem_o[0]  = 32'(rem_a);
  assign root_o[1] = 32'(root_b);
  assign rem_o[1]  = 32'(rem_b);
  assign root_o[2] = 32'(root_c);
  assign rem_o[2]  = 32'(rem_c);
  assign root_o[3] = 32'(root_d);
  assign rem_o[3]  = 32'(rem_d);

  int W_I    [4] = '{16, 16, 8, 32};
  int ITER_I [4] = '{8, 4, 1, 8};

  typedef struct {
    int                 inst;
    longint unsigned    rad;
    longint unsigned    root;
    longint unsigned    rem;
    int                 done_cyc;
  } exp_t;

  exp_t            sb[$];
  int              busy_from [4] = '{0, 0, 0, 0};
  int              idle_from [4] = '{0, 0, 0, 0};
  longint unsigned last_root [4] = '{0, 0, 0, 0};
  longint unsigned last_rem  [4] = '{0, 0, 0, 0};

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en   = 1'b0;
  logic rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit-by-bit search for the largest root with root*root <= a.
  function automatic longint unsigned isqrt(input longint unsigned a, input int w);
    longint unsigned root = 0;
    longint unsigned cand;
    for (int b = w / 2 - 1; b >= 0; b--) begin
      cand = root | (64'd1 << b);
      if (cand * cand <= a) root = cand;
    end
    return root;
  endfunction

  // Drive one cycle of inputs (called at a negedge) and update the model.
  task automatic drive(input logic init, input logic [31:0] v, input logic r);
    int              c;
    longint unsigned a;
    longint unsigned rt;
    exp_t            e;
    c       = cyc;
    in_init = init;
    rad     = v;
    rst     = r;
    if (r) begin
      for (int i = 0; i < 4; i++)
        if (idle_from[i] > c + 1) idle_from[i] = c + 1;
      for (int k = sb.size() - 1; k >= 0; k--)
        if (sb[k].done_cyc > c) sb.delete(k);
    end else if (init) begin
      for (int i = 0; i < 4; i++) begin
        if (c >= idle_from[i]) begin
          a  = 64'(v) & ((64'd1 << W_I[i]) - 1);
          rt = isqrt(a, W_I[i]);
          e.inst     = i;
          e.rad      = a;
          e.root     = rt;
          e.rem      = a - rt * rt;
          e.done_cyc = c + ITER_I[i] + 1;
          sb.push_back(e);
          busy_from[i] = c + 1;
          idle_from[i] = c + ITER_I[i] + 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int target;
    int guard;
    target = 0;
    for (int i = 0; i < 4; i++)
      if (idle_from[i] > target) target = idle_from[i];
    guard = 0;
    while (cyc < target && guard < 200) begin
      drive(1'b0, $urandom, 1'b0);
      guard++;
    end
    if (cyc < target) check("wait_bound", 64'd0, 64'd1);
  endtask

  exp_t e_m;
  int   hit;
  logic exp_done;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (rst_seen) begin
          last_root[i] = 0;
          last_rem[i]  = 0;
        end
        exp_done = 1'b0;
        hit      = -1;
        for (int k = 0; k < sb.size(); k++)
          if (sb[k].inst == i && sb[k].done_cyc == cyc) hit = k;
        if (hit >= 0) begin
          e_m = sb[hit];
          sb.delete(hit);
          exp_done     = 1'b1;
          last_root[i] = e_m.root;
          last_rem[i]  = e_m.rem;
          check($sformatf("u%0d_identity", i),
                64'(root_o[i]) * 64'(root_o[i]) + 64'(rem_o[i]), e_m.rad);
          check($sformatf("u%0d_rem_bound", i),
                64'(64'(rem_o[i]) <= 2 * 64'(root_o[i])), 64'd1);
        end
        check($sformatf("u%0d_done", i), 64'(done_w[i]), 64'(exp_done));
        check($sformatf("u%0d_busy", i), 64'(busy_w[i]),
              64'(cyc >= busy_from[i] && cyc < idle_from[i]));
        check($sformatf("u%0d_root", i), 64'(root_o[i]), last_root[i]);
        check($sformatf("u%0d_rem", i), 64'(rem_o[i]), last_rem[i]);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    in_init = 1'b0;
    rad     = '0;
    repeat (3) @(negedge clk);
    check("rst_root", 64'(root_o[0]), 64'd0);
    check("rst_rem", 64'(rem_o[0]), 64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_done", 64'(done_w[0]), 64'd0);
    mon_en = 1'b1;
    drive(1'b0, 32'd0, 1'b0);

    drive(1'b1, 32'd144, 1'b0);
    wait_idle();
    check("w16u1_144_root", 64'(root_o[0]), 64'd12);
    check("w16u1_144_rem", 64'(rem_o[0]), 64'd0);
    check("w8u4_144_root", 64'(root_o[2]), 64'd12);

    drive(1'b1, 32'd65535, 1'b0);
    wait_idle();
    check("w16u1_max_root", 64'(root_o[0]), 64'd255);
    check("w16u1_max_rem", 64'(rem_o[0]), 64'd510);
    check("w8u4_255_rem", 64'(rem_o[2]), 64'd30);

    drive(1'b1, 32'd0, 1'b0);
    wait_idle();
    check("zero_root", 64'(root_o[0]), 64'd0);
    check("zero_rem", 64'(rem_o[0]), 64'd0);

    drive(1'b1, 32'd1, 1'b0);
    wait_idle();
    check("one_root", 64'(root_o[0]), 64'd1);
    check("one_rem", 64'(rem_o[0]), 64'd0);

    drive(1'b1, 32'd200, 1'b0);
    wait_idle();
    check("w16u2_200_root", 64'(root_o[1]), 64'd14);
    check("w16u2_200_rem", 64'(rem_o[1]), 64'd4);

    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check("w32_max_root", 64'(root_o[3]), 64'd65535);
    check("w32_max_rem", 64'(rem_o[3]), 64'd131070);

    // Start while busy is ignored.
    drive(1'b1, 32'd144, 1'b0);
    drive(1'b0, 32'd5, 1'b0);
    drive(1'b1, 32'd99, 1'b0);
    drive(1'b0, 32'd7, 1'b0);
    wait_idle();
    check("busy_ign_root", 64'(root_o[0]), 64'd12);

    // Reset in the 4th CALC cycle aborts without a done pulse.
    drive(1'b1, 32'd65535, 1'b0);
    repeat (3) drive(1'b0, 32'd3, 1'b0);
    drive(1'b0, 32'd3, 1'b1);
    check("abort_root", 64'(root_o[0]), 64'd0);
    check("abort_rem", 64'(rem_o[0]), 64'd0);
    check("abort_busy", 64'(busy_w[0]), 64'd0);
    drive(1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'd81, 1'b0);
    wait_idle();
    check("after_abort_root", 64'(root_o[0]), 64'd9);
    check("after_abort_rem", 64'(rem_o[0]), 64'd0);

    // Reset and start together: reset wins.
    drive(1'b1, 32'd77, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    check("rst_wins_busy", 64'(busy_w[0]), 64'd0);

    // Random starts, operands changing every cycle, occasional reset.
    repeat (3000) drive(($urandom % 3) == 0, $urandom, ($urandom % 300) == 0);
    wait_idle();
    drive(1'b0, 32'd0, 1'b0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
